ecc_point_sequencer: RTL and testbench
======================================

Name: ecc_point_sequencer

Overview:
- Upstream controller for the ECC field-arithmetic core (ALU with add/sub/mult/inv, one-cycle `done` pulse).
- Computes one affine elliptic-curve point operation over GF(p): point addition R = P1 + P2, or point doubling R = 2·P1.
- Works by stepping a fixed micro-program of field ops. Each step drives the core's operands, select and start; captures the result into a local 16×256 register file.
- Feeds results to the scalar-multiplication loop above it.

Parameters:
- W, 256, field element width.
- NREG, 16, register-file depth (R0 x1, R1 y1, R2 x2, R3 y2, R4 a_curve, R5–R15 temporaries).
- TIMEOUT, 4096, maximum cycles to wait for core done per step before error.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start request, sampled in IDLE only
- i_mode  in  1  0 = point add, 1 = point double
- i_x1, i_y1, i_x2, i_y2  in  W  input point coordinates (x2/y2 ignored when doubling)
- i_a_curve  in  W  curve coefficient a
- i_prime  in  W  field prime p
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done; degenerate input or core timeout
- o_x3, o_y3  out  W  result, held until next accepted start
- o_core_start  out  1  one-cycle start to core
- o_core_sel  out  3  001 add, 010 sub, 011 mult, 100 inv, 000 nop
- o_core_a, o_core_b, o_core_prime  out  W  core operands
- i_core_result  in  W  core result, valid only while i_core_done
- i_core_done  in  1  core completion pulse

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous, active-high on i_rst.
- Reset values: state IDLE; all outputs 0; register file contents don't-care.
- Reset mid-operation aborts immediately. No o_done is produced. The core is reset by its own reset, tied externally.
- Core semantics: INV returns b·a⁻¹ mod p. The divisor goes on o_core_a, the numerator on o_core_b.
- Core handshake:
  - o_core_start is high exactly one cycle per step.
  - o_core_a, o_core_b, o_core_sel and o_core_prime are held stable from ISSUE until the i_core_done cycle.
  - The result is captured only on the i_core_done cycle.
- State IDLE:
  - On i_start: load R0–R4 from the inputs, latch i_mode and i_prime, clear the step counter, set o_busy → CHECK.
  - i_start while busy is ignored.
- State CHECK (1 cycle):
  - Add mode with x1 == x2, or double mode with y1 == 0 → DONE with err = 1. No core ops are issued.
  - Otherwise → ISSUE.
- State ISSUE (1 cycle): drive the operands for the current ROM step, pulse o_core_start, clear the timeout counter → WAIT.
- State WAIT:
  - On i_core_done → WRITE, latching the result.
  - If the timeout counter reaches TIMEOUT-1 → DONE with err = 1.
- State WRITE (1 cycle):
  - Write the result to the destination register.
  - If this was the last step → DONE, else increment the step counter → ISSUE.
- State DONE (1 cycle):
  - o_done = 1; o_err as set.
  - o_x3/o_y3 are taken from the result registers when err = 0; they are left unchanged when err = 1.
  - Clear o_busy → IDLE.
- Add program (9 steps):
  - R5 = R3 − R1
  - R6 = R2 − R0
  - R7 = INV(a = R6, b = R5)
  - R8 = R7·R7
  - R9 = R8 − R0
  - R10 = R9 − R2 (x3)
  - R11 = R0 − R10
  - R12 = R7·R11
  - R13 = R12 − R1 (y3)
- Double program (12 steps):
  - R5 = R0·R0
  - R6 = R5 + R5
  - R6 = R6 + R5
  - R6 = R6 + R4
  - R7 = R1 + R1
  - R8 = INV(a = R7, b = R6)
  - R9 = R8·R8
  - R10 = R0 + R0
  - R11 = R9 − R10 (x3)
  - R12 = R0 − R11
  - R13 = R8·R12
  - R14 = R13 − R1 (y3)
- Latency: start → o_done = 2 + Σ(2 + Lk) cycles, where Lk is the core latency for step k (ISSUE to done).
- Width: all values are W bits. Inputs are assumed already reduced mod p; no range check is performed.
- Point at infinity is not representable; callers handle it.

Decomposition:
- Package ecc_pkg holds:
  - the alu_sel_e enum (NOP/ADD/SUB/MULT/INV);
  - the seq_state_e enum;
  - the uop_t struct {sel, srcA[3:0], srcB[3:0], dst[3:0]};
  - the register index constants;
  - the ADD_LEN = 9 and DBL_LEN = 12 constants.
- Sub-module ecc_uop_rom: combinational, input {mode, step}, output uop_t plus a last flag.

Test Plan (core replaced by a behavioural model with configurable fixed latency L; p = 17, a = 2):
- Double, mode = 1, x1 = 5, y1 = 1, L = 3 → o_done with (x3, y3) = (6, 3), err = 0. Latency 2 + 12·5 = 62 cycles; exactly 12 core start pulses.
- Add, mode = 0, (5,1) + (6,3), L = 3 → (10, 6), err = 0. Latency 47 cycles.
- Add with x1 = x2 = 5 → o_done 2 cycles after start, err = 1, zero core starts, o_x3/o_y3 unchanged.
- Double with y1 = 0 → err = 1 in CHECK, no core starts.
- Core never returns done, TIMEOUT = 16 → o_done with err = 1 after the first ISSUE + 16 wait cycles.
- i_start pulsed while busy → ignored, first op completes correctly. i_rst during WAIT → outputs 0 next cycle, no o_done; a new start then completes normally.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC point-operation sequencer.
package ecc_pkg;

    typedef enum logic [2:0] {
        SEL_NOP  = 3'b000,
        SEL_ADD  = 3'b001,
        SEL_SUB  = 3'b010,
        SEL_MULT = 3'b011,
        SEL_INV  = 3'b100
    } alu_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        alu_sel_e   sel;
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst;
    } uop_t;

    localparam logic [3:0] REG_X1 = 4'd0;
    localparam logic [3:0] REG_Y1 = 4'd1;
    localparam logic [3:0] REG_X2 = 4'd2;
    localparam logic [3:0] REG_Y2 = 4'd3;
    localparam logic [3:0] REG_A  = 4'd4;

    localparam logic [3:0] ADD_X3_REG = 4'd10;
    localparam logic [3:0] DBL_X3_REG = 4'd11;

    localparam int unsigned ADD_LEN = 9;
    localparam int unsigned DBL_LEN = 12;

    function automatic uop_t mk_uop(alu_sel_e s, logic [3:0] a, logic [3:0] b, logic [3:0] d);
        uop_t u;
        u.sel   = s;
        u.src_a = a;
        u.src_b = b;
        u.dst   = d;
        return u;
    endfunction

endpackage

// File: rtl/ecc_uop_rom.sv
// Micro-program ROM: affine point add (9 steps) and point double (12 steps).
module ecc_uop_rom
    import ecc_pkg::*;
(
    input  logic       i_mode,
    input  logic [3:0] i_step,
    output uop_t       o_uop,
    output logic       o_last
);

    always_comb begin
        o_uop  = mk_uop(SEL_NOP, 4'd0, 4'd0, 4'd0);
        o_last = 1'b0;
        if (!i_mode) begin
            o_last = (i_step == 4'(ADD_LEN - 1));
            case (i_step)
                4'd0:    o_uop = mk_uop(SEL_SUB,  REG_Y2, REG_Y1, 4'd5);
                4'd1:    o_uop = mk_uop(SEL_SUB,  REG_X2, REG_X1, 4'd6);
                4'd2:    o_uop = mk_uop(SEL_INV,  4'd6,   4'd5,   4'd7);
                4'd3:    o_uop = mk_uop(SEL_MULT, 4'd7,   4'd7,   4'd8);
                4'd4:    o_uop = mk_uop(SEL_SUB,  4'd8,   REG_X1, 4'd9);
                4'd5:    o_uop = mk_uop(SEL_SUB,  4'd9,   REG_X2, 4'd10);
                4'd6:    o_uop = mk_uop(SEL_SUB,  REG_X1, 4'd10,  4'd11);
                4'd7:    o_uop = mk_uop(SEL_MULT, 4'd7,   4'd11,  4'd12);
                4'd8:    o_uop = mk_uop(SEL_SUB,  4'd12,  REG_Y1, 4'd13);
                default: o_uop = mk_uop(SEL_NOP,  4'd0,   4'd0,   4'd0);
            endcase
        end else begin
            o_last = (i_step == 4'(DBL_LEN - 1));
            case (i_step)
                4'd0:    o_uop = mk_uop(SEL_MULT, REG_X1, REG_X1, 4'd5);
                4'd1:    o_uop = mk_uop(SEL_ADD,  4'd5,   4'd5,   4'd6);
                4'd2:    o_uop = mk_uop(SEL_ADD,  4'd6,   4'd5,   4'd6);
                4'd3:    o_uop = mk_uop(SEL_ADD,  4'd6,   REG_A,  4'd6);
                4'd4:    o_uop = mk_uop(SEL_ADD,  REG_Y1, REG_Y1, 4'd7);
                4'd5:    o_uop = mk_uop(SEL_INV,  4'd7,   4'd6,   4'd8);
                4'd6:    o_uop = mk_uop(SEL_MULT, 4'd8,   4'd8,   4'd9);
                4'd7:    o_uop = mk_uop(SEL_ADD,  REG_X1, REG_X1, 4'd10);
                4'd8:    o_uop = mk_uop(SEL_SUB,  4'd9,   4'd10,  4'd11);
                4'd9:    o_uop = mk_uop(SEL_SUB,  REG_X1, 4'd11,  4'd12);
                4'd10:   o_uop = mk_uop(SEL_MULT, 4'd8,   4'd12,  4'd13);
                4'd11:   o_uop = mk_uop(SEL_SUB,  4'd13,  REG_Y1, 4'd14);
                default: o_uop = mk_uop(SEL_NOP,  4'd0,   4'd0,   4'd0);
            endcase
        end
    end

endmodule

// File: rtl/ecc_point_sequencer.sv
// Steps the point add/double micro-program through the external field-arithmetic core
// and collects intermediate values in a local register file.
module ecc_point_sequencer
    import ecc_pkg::*;
#(
    parameter int W       = 256,
    parameter int NREG    = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_mode,
    input  logic [W-1:0] i_x1,
    input  logic [W-1:0] i_y1,
    input  logic [W-1:0] i_x2,
    input  logic [W-1:0] i_y2,
    input  logic [W-1:0] i_a_curve,
    input  logic [W-1:0] i_prime,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [W-1:0] o_x3,
    output logic [W-1:0] o_y3,
    output logic         o_core_start,
    output logic [2:0]   o_core_sel,
    output logic [W-1:0] o_core_a,
    output logic [W-1:0] o_core_b,
    output logic [W-1:0] o_core_prime,
    input  logic [W-1:0] i_core_result,
    input  logic         i_core_done
);

    localparam int TW = $clog2(TIMEOUT);

    seq_state_e   r_state;
    logic [W-1:0] r_rf [NREG];
    logic         r_mode;
    logic [3:0]   r_step;
    logic [3:0]   r_dst;
    logic         r_last;
    logic [TW-1:0] r_tmo;
    logic [W-1:0] r_result;
    logic         r_busy, r_done, r_err;
    logic [W-1:0] r_x3, r_y3;
    logic         r_core_start;
    alu_sel_e     r_core_sel;
    logic [W-1:0] r_core_a, r_core_b, r_core_prime;

    logic [3:0]   w_issue_step;
    uop_t         w_uop;
    logic         w_last;
    logic [W-1:0] w_opa, w_opb;
    logic         w_degenerate;

    // Core outputs are registered on entry to ISSUE, so the ROM is addressed with the step about to issue.
    always_comb begin
        w_issue_step = (r_state == ST_WRITE) ? r_step + 4'd1 : r_step;
    end

    ecc_uop_rom u_rom (
        .i_mode (r_mode),
        .i_step (w_issue_step),
        .o_uop  (w_uop),
        .o_last (w_last)
    );

    // The result being written this cycle is forwarded to the next step's operand reads.
    always_comb begin
        w_opa = r_rf[w_uop.src_a];
        w_opb = r_rf[w_uop.src_b];
        if (r_state == ST_WRITE) begin
            if (w_uop.src_a == r_dst) w_opa = r_result;
            if (w_uop.src_b == r_dst) w_opb = r_result;
        end
        w_degenerate = r_mode ? (r_rf[REG_Y1] == '0) : (r_rf[REG_X1] == r_rf[REG_X2]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= 1'b0;
            r_step       <= '0;
            r_dst        <= '0;
            r_last       <= 1'b0;
            r_tmo        <= '0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_x3         <= '0;
            r_y3         <= '0;
            r_core_start <= 1'b0;
            r_core_sel   <= SEL_NOP;
            r_core_a     <= '0;
            r_core_b     <= '0;
            r_core_prime <= '0;
        end else begin
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_rf[REG_X1] <= i_x1;
                        r_rf[REG_Y1] <= i_y1;
                        r_rf[REG_X2] <= i_x2;
                        r_rf[REG_Y2] <= i_y2;
                        r_rf[REG_A]  <= i_a_curve;
                        r_mode       <= i_mode;
                        r_core_prime <= i_prime;
                        r_step       <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_degenerate) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_core_start <= 1'b1;
                        r_core_sel   <= w_uop.sel;
                        r_core_a     <= w_opa;
                        r_core_b     <= w_opb;
                        r_dst        <= w_uop.dst;
                        r_last       <= w_last;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_core_done) begin
                        r_result <= i_core_result;
                        r_state  <= ST_WRITE;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_rf[r_dst] <= r_result;
                    if (r_last) begin
                        // The final step always produces y3, so it is taken straight from the result.
                        r_done  <= 1'b1;
                        r_x3    <= r_rf[r_mode ? DBL_X3_REG : ADD_X3_REG];
                        r_y3    <= r_result;
                        r_state <= ST_DONE;
                    end else begin
                        r_step       <= r_step + 4'd1;
                        r_core_start <= 1'b1;
                        r_core_sel   <= w_uop.sel;
                        r_core_a     <= w_opa;
                        r_core_b     <= w_opb;
                        r_dst        <= w_uop.dst;
                        r_last       <= w_last;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_x3         = r_x3;
    assign o_y3         = r_y3;
    assign o_core_start = r_core_start;
    assign o_core_sel   = r_core_sel;
    assign o_core_a     = r_core_a;
    assign o_core_b     = r_core_b;
    assign o_core_prime = r_core_prime;

endmodule

// File: tb/tb_ecc_point_sequencer.sv
// Bench for ecc_point_sequencer: behavioural field core plus an affine-formula point reference.
module tb_ecc_point_sequencer;

    localparam int W   = 256;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [W-1:0] x1, y1, x2, y2, acv, prime;
    logic         busy, done, err, core_start, core_done;
    logic [W-1:0] x3, y3, core_a, core_b, core_prime, core_result;
    logic [2:0]   core_sel;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     core_lat  = 3;
    bit     core_mute = 1'b0;
    int     n_starts  = 0;
    int     pend      = 0;
    longint pend_res  = 0;
    longint exp_x3 = 0, exp_y3 = 0;

    always #5 clk = ~clk;

    ecc_point_sequencer #(.W(W), .NREG(16), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
        .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2),
        .i_a_curve(acv), .i_prime(prime),
        .o_busy(busy), .o_done(done), .o_err(err), .o_x3(x3), .o_y3(y3),
        .o_core_start(core_start), .o_core_sel(core_sel),
        .o_core_a(core_a), .o_core_b(core_b), .o_core_prime(core_prime),
        .i_core_result(core_result), .i_core_done(core_done)
    );

    function automatic longint md(longint v, longint p);
        return ((v % p) + p) % p;
    endfunction

    function automatic longint inv(longint a, longint p);
        for (longint i = 1; i < p; i++) if (md(a * i, p) == 1) return i;
        return 0;
    endfunction

    function automatic longint alu(logic [2:0] sel, longint a, longint b, longint p);
        case (sel)
            3'b001:  return md(a + b, p);
            3'b010:  return md(a - b, p);
            3'b011:  return md(a * b, p);
            3'b100:  return md(b * inv(a, p), p);
            default: return 0;
        endcase
    endfunction

    // Behavioural field core: done arrives core_lat cycles after the start cycle.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (rst) begin
            pend = 0;
        end else if (core_start) begin
            n_starts++;
            pend_res = alu(core_sel, longint'(core_a[63:0]), longint'(core_b[63:0]),
                           longint'(core_prime[63:0]));
            if (!core_mute) begin
                if (core_lat == 1) begin
                    core_done   <= 1'b1;
                    core_result <= W'(pend_res);
                end else begin
                    pend = core_lat;
                end
            end
        end else if (pend > 0) begin
            pend--;
            if (pend == 1) begin
                core_done   <= 1'b1;
                core_result <= W'(pend_res);
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ref_point(input bit m, input longint px1, py1, px2, py2, a, p,
                             output longint rx3, output longint ry3, output bit rerr);
        longint lam;
        rerr = 1'b0; rx3 = 0; ry3 = 0;
        if (!m) begin
            if (px1 == px2) begin rerr = 1'b1; return; end
            lam = md(md(py2 - py1, p) * inv(md(px2 - px1, p), p), p);
            rx3 = md(lam * lam - px1 - px2, p);
        end else begin
            if (py1 == 0) begin rerr = 1'b1; return; end
            lam = md(md(3 * px1 * px1 + a, p) * inv(md(2 * py1, p), p), p);
            rx3 = md(lam * lam - 2 * px1, p);
        end
        ry3 = md(lam * md(px1 - rx3, p) - py1, p);
    endtask

    task automatic run_op(input string tag, input bit m, input longint px1, py1, px2, py2, a, p,
                          input int lat, input bit mute, input int poke_at);
        longint ex3, ey3;
        bit     eerr, got_done;
        int     elat, esteps, cyc, n0;
        ref_point(m, px1, py1, px2, py2, a, p, ex3, ey3, eerr);
        if (eerr) begin
            elat = 2; esteps = 0;
        end else if (mute) begin
            elat = 3 + TMO; esteps = 1; eerr = 1'b1;
        end else begin
            esteps = m ? 12 : 9;
            elat   = 2 + esteps * (2 + lat);
            exp_x3 = ex3; exp_y3 = ey3;
        end
        core_lat = lat; core_mute = mute;
        @(negedge clk);
        mode = m; x1 = W'(px1); y1 = W'(py1); x2 = W'(px2); y2 = W'(py2);
        acv = W'(a); prime = W'(p); start = 1'b1;
        n0 = n_starts;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy"}, W'(busy), W'(1));
        cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == poke_at) begin
                start = 1'b1; mode = ~m; x1 = W'($urandom_range(0, 16));
            end else begin
                start = 1'b0;
            end
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        check({tag, " done_seen"}, W'(got_done), W'(1));
        check({tag, " latency"}, W'(cyc + 1), W'(elat));
        check({tag, " err"}, W'(err), W'(eerr));
        check({tag, " x3"}, x3, W'(exp_x3));
        check({tag, " y3"}, y3, W'(exp_y3));
        check({tag, " core_starts"}, W'(n_starts - n0), W'(esteps));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, W'(done), W'(0));
        check({tag, " busy_clear"}, W'(busy), W'(0));
    endtask

    initial begin
        longint plist [5] = '{17, 23, 97, 251, 8191};
        longint p, a, rx1, ry1, rx2, ry2;
        bit     m;
        int     n_done_seen;

        rst = 1'b1; start = 1'b0; mode = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; acv = '0; prime = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst x3", x3, '0);
        check("rst core_start", W'(core_start), W'(0));
        check("rst core_sel", W'(core_sel), W'(0));
        rst = 1'b0;

        run_op("dbl_5_1", 1'b1, 5, 1, 0, 0, 2, 17, 3, 1'b0, 0);
        check("dbl_5_1 const_x3", x3, W'(6));
        check("dbl_5_1 const_y3", y3, W'(3));
        run_op("add_5_1_6_3", 1'b0, 5, 1, 6, 3, 2, 17, 3, 1'b0, 0);
        check("add const_x3", x3, W'(10));
        check("add const_y3", y3, W'(6));
        run_op("add_x_equal", 1'b0, 5, 1, 5, 3, 2, 17, 3, 1'b0, 0);
        run_op("dbl_y_zero", 1'b1, 5, 0, 0, 0, 2, 17, 3, 1'b0, 0);
        run_op("timeout", 1'b1, 5, 1, 0, 0, 2, 17, 3, 1'b1, 0);
        run_op("start_busy", 1'b1, 5, 1, 0, 0, 2, 17, 3, 1'b0, 5);

        // Abort in the middle of a core wait.
        core_lat = 3; core_mute = 1'b0;
        @(negedge clk);
        mode = 1'b1; x1 = W'(5); y1 = W'(1); acv = W'(2); prime = W'(17); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        check("abort x3", x3, '0);
        check("abort y3", y3, '0);
        check("abort core_start", W'(core_start), W'(0));
        check("abort core_a", core_a, '0);
        check("abort core_prime", core_prime, '0);
        n_done_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) n_done_seen++;
        end
        check("abort no_done", W'(n_done_seen), W'(0));
        exp_x3 = 0; exp_y3 = 0;
        run_op("after_abort", 1'b0, 5, 1, 6, 3, 2, 17, 2, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            p   = plist[$urandom_range(0, 4)];
            a   = longint'($urandom_range(0, 1000)) % p;
            rx1 = longint'($urandom_range(0, 9000)) % p;
            ry1 = longint'($urandom_range(0, 9000)) % p;
            rx2 = longint'($urandom_range(0, 9000)) % p;
            ry2 = longint'($urandom_range(0, 9000)) % p;
            m   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                rx2 = rx1; ry1 = 0;
            end
            run_op($sformatf("rnd%0d", i), m, rx1, ry1, rx2, ry2, a, p,
                   int'($urandom_range(1, 4)), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
